// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI responder.
// Frame bit positions, FSM states and the per-channel input register.
package dac_spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int CH_SEL_BIT = 15;
   localparam int GA_N_BIT   = 13;
   localparam int SHDN_N_BIT = 12;
   localparam int CODE_MSB   = 11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      OVERRUN = 2'd2
   } state_t;

   typedef struct packed {
      logic [CODE_MSB:0] code;
      logic              ga_n;
      logic              shdn_n;
   } chan_reg_t;

   // Reset image: code 0, 1x gain, shut down.
   localparam chan_reg_t CHAN_RST = '{code: '0, ga_n: 1'b1, shdn_n: 1'b0};

endpackage

// File: rtl/dac_spi_responder_sync_edge.sv
// Multi-flop synchronizer with edge detection for one async input.
// Ports: clk, rst (sync active-low), d (async in), q (synced level), rise, fall.
module sync_edge #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sr;
   logic              dly;

   // Reset to the pin's idle level so release does not fake an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sr  <= {STAGES{INIT}};
         dly <= INIT;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            sr[i] <= sr[i-1];
         end
         dly <= sr[STAGES-1];
      end
   end

   assign q    = sr[STAGES-1];
   assign rise = sr[STAGES-1] & ~dly;
   assign fall = ~sr[STAGES-1] & dly;

endmodule

// File: rtl/dac_spi_responder.sv
// DAC-side SPI responder: decodes 16-bit write frames into dual-channel
// input registers and transfers them to the outputs on LDAC falling.
// Ports: clk, rst (sync active-low), sck/sdi/CS/LDAC (async SPI pins),
// dac_a/dac_b (codes), gain2x/shdn ([0]=A,[1]=B), frame_valid/frame_err/latched (pulses).
module dac_spi_responder #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sck,
   input  logic        sdi,
   input  logic        CS,
   input  logic        LDAC,
   output logic [11:0] dac_a,
   output logic [11:0] dac_b,
   output logic [1:0]  gain2x,
   output logic [1:0]  shdn,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        latched
);

   import dac_spi_pkg::*;

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

   logic sck_rise, sck_lvl_unused, sck_fall_unused;
   logic sdi_s, sdi_rise_unused, sdi_fall_unused;
   logic cs_rise, cs_fall, cs_lvl_unused;
   logic ldac_fall, ldac_lvl_unused, ldac_rise_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
      .clk(clk), .rst(rst), .d(sck),
      .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sdi (
      .clk(clk), .rst(rst), .d(sdi),
      .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
      .clk(clk), .rst(rst), .d(CS),
      .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ldac (
      .clk(clk), .rst(rst), .d(LDAC),
      .q(ldac_lvl_unused), .rise(ldac_rise_unused), .fall(ldac_fall)
   );

   state_t                st_q, st_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d;
   logic                  commit, err;
   chan_reg_t             in_a, in_b, out_a, out_b, frame;
   logic                  unused_buf;

   assign frame = '{code:   sh_q[CODE_MSB:0],
                    ga_n:   sh_q[GA_N_BIT],
                    shdn_n: sh_q[SHDN_N_BIT]};
   assign unused_buf = sh_q[CH_SEL_BIT-1];

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      commit = 1'b0;
      err    = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (cs_fall && !cs_rise) begin
               cnt_d = '0;
               sh_d  = '0;
               st_d  = RECV;
            end
         end
         RECV: begin
            // CS rising takes priority; a coincident sck edge is dropped.
            if (cs_rise) begin
               if (cnt_q == FULL) commit = 1'b1;
               else               err    = 1'b1;
               st_d = IDLE;
            end else if (sck_rise) begin
               if (cnt_q == FULL) begin
                  st_d = OVERRUN;
               end else begin
                  sh_d  = {sh_q[FRAME_BITS-2:0], sdi_s};
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         OVERRUN: begin
            if (cs_rise) begin
               err  = 1'b1;
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // Input registers update on commit; outputs copy one clk after the
   // latched pulse is raised, so a same-clk commit is already visible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q        <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         in_a        <= CHAN_RST;
         in_b        <= CHAN_RST;
         out_a       <= CHAN_RST;
         out_b       <= CHAN_RST;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         latched     <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         frame_valid <= commit;
         frame_err   <= err;
         latched     <= ldac_fall;
         if (commit) begin
            if (sh_q[CH_SEL_BIT]) in_b <= frame;
            else                  in_a <= frame;
         end
         if (latched) begin
            out_a <= in_a;
            out_b <= in_b;
         end
      end
   end

   assign dac_a  = out_a.code;
   assign dac_b  = out_b.code;
   assign gain2x = {~out_b.ga_n, ~out_a.ga_n};
   assign shdn   = {~out_b.shdn_n, ~out_a.shdn_n};

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder.
// Drives SPI frames and LDAC strobes, counts pulses and checks outputs.
module tb_dac_spi_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sck = 1'b0;
   logic        sdi = 1'b0;
   logic        CS = 1'b1;
   logic        LDAC = 1'b1;
   logic [11:0] dac_a, dac_b;
   logic [1:0]  gain2x, shdn;
   logic        frame_valid, frame_err, latched;

   int total = 0;
   int bad = 0;
   int nv = 0, ne = 0, nl = 0;
   int v0, e0, l0;

   dac_spi_responder dut (
      .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .CS(CS), .LDAC(LDAC),
      .dac_a(dac_a), .dac_b(dac_b), .gain2x(gain2x), .shdn(shdn),
      .frame_valid(frame_valid), .frame_err(frame_err), .latched(latched)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) nv <= nv + 1;
      if (frame_err)   ne <= ne + 1;
      if (latched)     nl <= nl + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         sdi = v[i];
         tick(4);
         sck = 1'b1;
         tick(4);
         sck = 1'b0;
      end
   endtask

   // Full frame; optionally drops LDAC in the same instant CS rises.
   task automatic frame(input logic [31:0] v, input int n, input bit ld);
      CS = 1'b0;
      tick(4);
      bits(v, n);
      tick(4);
      chk($sformatf("state_%0d", n), int'(dut.st_q), (n > 16) ? 2 : 1);
      CS = 1'b1;
      if (ld) LDAC = 1'b0;
      tick(8);
      if (ld) begin
         LDAC = 1'b1;
         tick(4);
      end
   endtask

   task automatic strobe();
      LDAC = 1'b0;
      tick(8);
      LDAC = 1'b1;
      tick(4);
   endtask

   initial begin
      tick(4);
      rst = 1'b1;
      tick(2);
      @(negedge clk);
      chk("rst_dac_a", dac_a, 0);
      chk("rst_dac_b", dac_b, 0);
      chk("rst_shdn", shdn, 2'b11);
      chk("rst_gain", gain2x, 0);
      chk("rst_pulses", nv + ne + nl, 0);
      tick(1);

      // channel A, 1x, active, code 0A5
      v0 = nv; e0 = ne; l0 = nl;
      frame(32'h30A5, 16, 1'b0);
      chk("t1_valid", nv - v0, 1);
      chk("t1_err", ne - e0, 0);
      chk("t1_hold_a", dac_a, 0);
      strobe();
      chk("t1_latched", nl - l0, 1);
      chk("t1_dac_a", dac_a, 12'h0A5);
      chk("t1_shdn", shdn, 2'b10);
      chk("t1_gain", gain2x, 2'b00);
      chk("t1_dac_b", dac_b, 0);

      // B at 2x then A (bit13 clear, so also 2x), one latch
      v0 = nv; l0 = nl;
      frame(32'h9FFF, 16, 1'b0);
      frame(32'h1123, 16, 1'b0);
      chk("t2_valid", nv - v0, 2);
      chk("t2_hold_b", dac_b, 0);
      strobe();
      chk("t2_latched", nl - l0, 1);
      chk("t2_dac_b", dac_b, 12'hFFF);
      chk("t2_dac_a", dac_a, 12'h123);
      chk("t2_gain", gain2x, 2'b11);
      chk("t2_shdn", shdn, 2'b00);

      // short and long frames are discarded
      v0 = nv; e0 = ne;
      frame(32'h3ABC, 15, 1'b0);
      chk("t3_short_err", ne - e0, 1);
      frame(32'h1FFFF, 17, 1'b0);
      chk("t3_long_err", ne - e0, 2);
      chk("t3_valid", nv - v0, 0);
      strobe();
      chk("t3_dac_a", dac_a, 12'h123);
      chk("t3_dac_b", dac_b, 12'hFFF);
      chk("t3_gain", gain2x, 2'b11);

      // CS rise and LDAC fall detected in the same clk
      v0 = nv; l0 = nl;
      frame(32'h3456, 16, 1'b1);
      tick(4);
      chk("t4_valid", nv - v0, 1);
      chk("t4_latched", nl - l0, 1);
      chk("t4_dac_a", dac_a, 12'h456);
      chk("t4_gain", gain2x, 2'b10);

      // reset after 8 bits of 3FFF
      e0 = ne;
      CS = 1'b0;
      tick(4);
      bits(32'h3F, 8);
      rst = 1'b0;
      CS = 1'b1;
      sck = 1'b0;
      tick(4);
      rst = 1'b1;
      tick(6);
      chk("t5_rst_dac_a", dac_a, 0);
      chk("t5_rst_state", int'(dut.st_q), 0);
      e0 = ne;
      v0 = nv;
      frame(32'h3001, 16, 1'b0);
      strobe();
      chk("t5_valid", nv - v0, 1);
      chk("t5_err", ne - e0, 0);
      chk("t5_dac_a", dac_a, 12'h001);
      chk("t5_dac_b", dac_b, 0);
      chk("t5_shdn", shdn, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
